imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader for the SISC core. Receives an image as a byte stream
//  (valid/ready), packs it into 32-bit words, writes them into instruction memory,
//  then releases the core from reset. Sits between the host link and the im write port.
//  Drives the core reset, so the core fetches only after the image is complete.
// PARAMETERS
//  ADDR_W     16     instruction memory address width (matches pc width)
//  DATA_W     32     instruction word width; fixed at 32, 4 bytes per word
//  BASE_ADDR  16'h0  im address of the first loaded word
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_f       in   1       asynchronous, active-low reset
//  rx_valid    in   1       host byte valid
//  rx_data     in   8       host byte
//  rx_ready    out  1       loader accepts a byte this cycle
//  im_addr     out  ADDR_W  im write address
//  im_wdata    out  DATA_W  im write data
//  im_we       out  1       im write strobe, one-cycle pulse per word
//  core_rst_f  out  1       active-low reset to the SISC core; low until load completes
//  load_done   out  1       sticky, image loaded successfully
//  load_err    out  1       sticky, checksum failure (only with CHECKSUM_EN)
// BEHAVIOUR
//  - Reset (rst_f=0, async): state=IDLE; rx_ready=0, im_we=0, im_addr=BASE_ADDR,
//    im_wdata=0, core_rst_f=0, load_done=0, load_err=0. Reset mid-load abandons the
//    load; words already written stay in im; the core is held in reset again.
//  - A byte transfers on a rising edge when rx_valid && rx_ready; rx_ready is a
//    function of state only and never depends on rx_valid.
//  - Frame: CNT_HI, CNT_LO (16-bit word count N, big-endian), then 4*N data bytes,
//    each word big-endian (first byte -> [31:24]), then [CSUM byte if CHECKSUM_EN].
//  - FSM: IDLE -> HDR_HI (unconditional, 1 cycle) -> HDR_LO -> DATA -> [CSUM] -> DONE|ERR.
//    rx_ready=1 in HDR_HI, HDR_LO, DATA, CSUM; rx_ready=0 in IDLE, DONE, ERR.
//    If N=0: HDR_LO -> CSUM (enabled) or DONE (disabled).
//  - Byte counter (2 bits) in DATA; a word index counter (16 bits) ends DATA after N words.
//  - Write: the cycle after a word's 4th byte transfers, im_we=1 for exactly one cycle with
//    im_addr = BASE_ADDR + word_index (mod 2^ADDR_W, wraps) and im_wdata = packed word.
//    Accepting the next byte in the same cycle as im_we is legal; no back-pressure is added.
//  - DONE: load_done=1 and core_rst_f=1, both registered, asserted the cycle after the last
//    im_we (or the CSUM accept / HDR_LO accept if N=0). They hold until rst_f.
//  - ERR: load_err=1, core_rst_f stays 0, rx_ready=0; exit only via rst_f.
//  - Extra bytes after DONE/ERR are not accepted (rx_ready=0).
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: running XOR over all header and data bytes; a trailing
//   CSUM byte must equal it -> DONE, else -> ERR. IMEM_LOADER_CHECKSUM_EN undefined:
//   no CSUM state; after the last data byte -> DONE; load_err is tied 0.
// STRUCTURE
//  Package sisc_ld_pkg: FSM state localparams (IDLE, HDR_HI, HDR_LO, DATA, CSUM,
//   DONE, ERR), byte-per-word constant (4), and the frame layout constants.
//  Sub-module imem_ld_pack: 4-byte shift packer with byte counter and word_valid
//   pulse; the top holds the FSM, address/count counters, checksum, and outputs.
// TESTING
//  1. N=2, bytes 00 02 DE AD BE EF 12 34 56 78 -> im_we @0000=DEADBEEF, @0001=12345678;
//     core_rst_f and load_done rise 1 cycle after the 2nd im_we.
//  2. Same frame with rx_valid toggling every other cycle plus random gaps -> identical
//     writes; no byte lost or duplicated; rx_ready never low in DATA.
//  3. N=0 (00 00) -> no im_we; load_done=1, core_rst_f=1; a further byte is not accepted.
//  4. rst_f pulsed low after 2 data bytes of word 0 -> no im_we, all outputs at reset
//     values; the full frame resent -> load succeeds.
//  5. CHECKSUM_EN, frame of test 1 plus CSUM 0x28 -> DONE; with 0x29 -> load_err=1,
//     core_rst_f stays 0, rx_ready=0.
//  6. BASE_ADDR=16'hFFFF, N=2 -> writes at FFFF then 0000 (wrap).

Source files
------------

// File: rtl/sisc_ld_pkg.sv
// Shared types and frame layout constants for the SISC boot image loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
package sisc_ld_pkg;

    // state  | meaning
    // IDLE   | post-reset, one cycle before accepting the header
    // HDR_HI | expecting word count high byte
    // HDR_LO | expecting word count low byte
    // DATA   | receiving image bytes, 4 per word, big-endian
    // CSUM   | expecting trailing checksum byte
    // DONE   | image loaded, core released
    // ERR    | checksum mismatch, core held in reset
    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } ld_state_t;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int CNT_W          = 16;

    localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

    // States in which the loader takes bytes from the host.
    function automatic logic is_rx_state(input ld_state_t s);
        return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_ld_pack.sv
// Packs a big-endian byte stream into 32-bit words; word_valid pulses for one
// cycle after the fourth byte of each word, with word stable until the next one.
module imem_ld_pack
    import sisc_ld_pkg::*;
(
    input  logic              clk,
    input  logic              rst_f,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              last_byte,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift;

    assign last_byte = (byte_cnt == LAST_BYTE_IDX);

    // Shift in accepted bytes and latch the completed word on the fourth.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            byte_cnt   <= '0;
            shift      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_en && last_byte;
            if (byte_en) begin
                shift    <= {shift[15:0], byte_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte)
                    word <= {shift, byte_data};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time image loader: header (16-bit word count), packed data words written
// to instruction memory, then the SISC core is released from reset.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
    import sisc_ld_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              im_we,
    output logic              core_rst_f,
    output logic              load_done,
    output logic              load_err
);

    ld_state_t         state;
    logic [BYTE_W-1:0] cnt_hi;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  word_idx;
    logic              accept;
    logic              pack_en;
    logic              last_byte;
    logic [WORD_W-1:0] pack_word;
    logic              pack_valid;

    assign rx_ready = is_rx_state(state);
    assign accept   = rx_valid && rx_ready;
    assign pack_en  = accept && (state == DATA);

    imem_ld_pack u_pack (
        .clk        (clk),
        .rst_f      (rst_f),
        .byte_en    (pack_en),
        .byte_data  (rx_data),
        .last_byte  (last_byte),
        .word       (pack_word),
        .word_valid (pack_valid)
    );

    // Write strobe and data come straight from the packer's registers.
    assign im_we    = pack_valid;
    assign im_wdata = pack_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;

    // Running XOR over header and data bytes.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)
            csum <= '0;
        else if (accept && (state != CSUM))
            csum <= csum ^ rx_data;
    end
`else
    assign load_err = 1'b0;
`endif

    // Load sequencing FSM with registered address and status outputs.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state      <= IDLE;
            cnt_hi     <= '0;
            word_cnt   <= '0;
            word_idx   <= '0;
            im_addr    <= BASE_ADDR;
            core_rst_f <= 1'b0;
            load_done  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            load_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: state <= HDR_HI;
                HDR_HI: begin
                    if (accept) begin
                        cnt_hi <= rx_data;
                        state  <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        word_cnt <= {cnt_hi, rx_data};
                        word_idx <= '0;
                        if ({cnt_hi, rx_data} == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            state      <= DONE;
                            load_done  <= 1'b1;
                            core_rst_f <= 1'b1;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept && last_byte) begin
                        im_addr  <= BASE_ADDR + ADDR_W'(word_idx);
                        word_idx <= word_idx + 16'd1;
                        // Status follows one cycle later from DONE, after the final im_we.
                        if (word_idx + 16'd1 == word_cnt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= DONE;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            state      <= DONE;
                            load_done  <= 1'b1;
                            core_rst_f <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    load_done  <= 1'b1;
                    core_rst_f <= 1'b1;
                end
                ERR: state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
